// File: rtl/pipe_adder_stream.sv
// Pipelined WIDTH-bit adder stream with valid/ready flow control and a wrapping completion counter.
// Optional feature macro ADDER_SAT_EN: clamp sums to WIDTH bits and flag saturated results on sat_flag.
module pipe_adder_stream #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  output logic [WIDTH:0]   add_out,
  output logic             d_vld,
  input  logic             out_rdy,
  output logic             sat_flag,
  output logic [CNT_W-1:0] txn_cnt
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipe_adder_stream: STAGES must be in 1..4");
  end

  logic [STAGES-1:0] vld_q;
  logic [WIDTH:0]    data_q [STAGES];
  logic [CNT_W-1:0]  txn_cnt_q;
  logic              adv;
  logic              accept;
  logic              out_fire;
  logic [WIDTH:0]    sum_full;
  logic [WIDTH:0]    sum_d;

  // Handshake: a transfer occurs at the rising edge where valid && ready are both high.
  // in_rdy is a function of pipeline state and out_rdy only, never of in_vld.
  assign d_vld    = vld_q[STAGES-1];
  assign adv      = !d_vld || out_rdy;
  assign in_rdy   = adv;
  assign accept   = in_vld && adv;
  assign out_fire = d_vld && out_rdy;
  assign add_out  = data_q[STAGES-1];
  assign txn_cnt  = txn_cnt_q;

  assign sum_full = {1'b0, add_in1} + {1'b0, add_in2};

`ifdef ADDER_SAT_EN
  logic              sat_d;
  logic [STAGES-1:0] sat_q;

  always_comb begin
    sum_d = sum_full;
    sat_d = 1'b0;
    if (sum_full[WIDTH]) begin
      sum_d = {1'b0, {WIDTH{1'b1}}};
      sat_d = 1'b1;
    end
  end

  // Saturation marker rides alongside its data so it is qualified by the same valid bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sat_q <= '0;
    end else if (adv) begin
      sat_q[0] <= accept && sat_d;
      for (int i = 1; i < STAGES; i++) begin
        sat_q[i] <= sat_q[i-1];
      end
    end
  end

  assign sat_flag = sat_q[STAGES-1];
`else
  assign sum_d    = sum_full;
  assign sat_flag = 1'b0;
`endif

  // Bubbles load zero data so add_out never carries stale or unknown values while d_vld=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
      txn_cnt_q <= '0;
    end else begin
      if (adv) begin
        vld_q[0]  <= accept;
        data_q[0] <= accept ? sum_d : '0;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
      if (out_fire) begin
        txn_cnt_q <= txn_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder_stream.sv
// Directed self-checking bench for pipe_adder_stream (WIDTH=4, STAGES=2), plus a CNT_W=4 copy for counter wrap.
module tb_pipe_adder_stream;

  logic       clock;
  logic       reset;
  logic       in_vld;
  logic       out_rdy;
  logic [3:0] add_in1;
  logic [3:0] add_in2;

  logic        in_rdy;
  logic [4:0]  add_out;
  logic        d_vld;
  logic        sat_flag;
  logic [15:0] txn_cnt;

  logic       in_rdy4;
  logic [4:0] add_out4;
  logic       d_vld4;
  logic       sat_flag4;
  logic [3:0] txn_cnt4;

  int n_vec;
  int n_err;

  logic [4:0] exp_q[$];

  pipe_adder_stream #(.WIDTH(4), .STAGES(2), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out), .d_vld(d_vld),
    .out_rdy(out_rdy), .sat_flag(sat_flag), .txn_cnt(txn_cnt)
  );

  pipe_adder_stream #(.WIDTH(4), .STAGES(2), .CNT_W(4)) u_dut_cnt4 (
    .clock(clock), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy4),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out4), .d_vld(d_vld4),
    .out_rdy(out_rdy), .sat_flag(sat_flag4), .txn_cnt(txn_cnt4)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset  = 1'b1;
    in_vld = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL reset_d_vld got=%b exp=0", d_vld); end
    n_vec++; if (add_out !== 5'd0) begin n_err++; $display("FAIL reset_add_out got=%0d exp=0", add_out); end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
    n_vec++; if (txn_cnt !== 16'd0) begin n_err++; $display("FAIL reset_txn_cnt got=%0d exp=0", txn_cnt); end
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
  endtask

  task automatic test_single();
    in_vld = 1'b1; add_in1 = 4'd3; add_in2 = 4'd5;
    step();
    in_vld = 1'b0;
    n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL single_early_vld got=%b exp=0", d_vld); end
    step();
    n_vec++; if (d_vld !== 1'b1) begin n_err++; $display("FAIL single_vld got=%b exp=1", d_vld); end
    n_vec++; if (add_out !== 5'd8) begin n_err++; $display("FAIL single_sum got=%0d exp=8", add_out); end
    step();
    n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL single_one_cycle got=%b exp=0", d_vld); end
    n_vec++; if (txn_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt got=%0d exp=1", txn_cnt); end
  endtask

  task automatic test_sat();
    logic [4:0] exp_sum;
    logic       exp_sat;
`ifdef ADDER_SAT_EN
    exp_sum = 5'b01111; exp_sat = 1'b1;
`else
    exp_sum = 5'b11110; exp_sat = 1'b0;
`endif
    in_vld = 1'b1; add_in1 = 4'd15; add_in2 = 4'd15;
    step();
    in_vld = 1'b0;
    step();
    n_vec++; if (d_vld !== 1'b1) begin n_err++; $display("FAIL sat_vld got=%b exp=1", d_vld); end
    n_vec++; if (add_out !== exp_sum) begin n_err++; $display("FAIL sat_sum got=%b exp=%b", add_out, exp_sum); end
    n_vec++; if (sat_flag !== exp_sat) begin n_err++; $display("FAIL sat_flag got=%b exp=%b", sat_flag, exp_sat); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_sum;
    pulse_reset();
    for (int s = 1; s <= 12; s++) begin
      if (s <= 10) begin
        in_vld = 1'b1; add_in1 = 4'(s - 1); add_in2 = 4'(s - 1);
      end else begin
        in_vld = 1'b0;
      end
      step();
      if (s >= 2 && s <= 11) begin
        exp_sum = 5'(2 * (s - 2));
        n_vec++; if (d_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld s=%0d got=%b exp=1", s, d_vld); end
        n_vec++; if (add_out !== exp_sum) begin n_err++; $display("FAIL b2b_sum s=%0d got=%0d exp=%0d", s, add_out, exp_sum); end
      end else begin
        n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL b2b_idle s=%0d got=%b exp=0", s, d_vld); end
      end
    end
    n_vec++; if (txn_cnt !== 16'd10) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=10", txn_cnt); end
  endtask

  task automatic test_stall();
    int         k;
    int         got;
    logic [4:0] exp_sum;
    pulse_reset();
    exp_q.delete();
    k   = 0;
    got = 0;
    for (int c = 0; c < 16; c++) begin
      out_rdy = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
      in_vld  = (k < 6);
      add_in1 = 4'(k + 1);
      add_in2 = 4'(k + 4);
      #1;
      if (c >= 2 && c <= 6) begin
        n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL stall_in_rdy c=%0d got=%b exp=0", c, in_rdy); end
        n_vec++; if (d_vld !== 1'b1) begin n_err++; $display("FAIL stall_vld c=%0d got=%b exp=1", c, d_vld); end
        n_vec++; if (add_out !== 5'd5) begin n_err++; $display("FAIL stall_hold c=%0d got=%0d exp=5", c, add_out); end
      end
      if (d_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stall_extra c=%0d got=%0d exp=none", c, add_out);
        end else begin
          exp_sum = exp_q.pop_front();
          got++;
          n_vec++; if (add_out !== exp_sum) begin n_err++; $display("FAIL stall_order c=%0d got=%0d exp=%0d", c, add_out, exp_sum); end
        end
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(5'(2 * k + 5));
        k++;
      end
      step();
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    n_vec++; if (got !== 6) begin n_err++; $display("FAIL stall_count got=%0d exp=6", got); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stall_leftover got=%0d exp=0", exp_q.size()); end
    n_vec++; if (txn_cnt !== 16'd6) begin n_err++; $display("FAIL stall_cnt got=%0d exp=6", txn_cnt); end
  endtask

  task automatic test_reset_midstream();
    in_vld = 1'b1; add_in1 = 4'd1; add_in2 = 4'd1;
    step();
    add_in1 = 4'd2; add_in2 = 4'd2;
    step();
    in_vld = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL rst_mid_vld got=%b exp=0", d_vld); end
    n_vec++; if (txn_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d exp=0", txn_cnt); end
    step();
    n_vec++; if (d_vld !== 1'b0) begin n_err++; $display("FAIL rst_mid_flushed got=%b exp=0", d_vld); end
    in_vld = 1'b1; add_in1 = 4'd7; add_in2 = 4'd1;
    step();
    in_vld = 1'b0;
    step();
    n_vec++; if (d_vld !== 1'b1) begin n_err++; $display("FAIL rst_mid_next_vld got=%b exp=1", d_vld); end
    n_vec++; if (add_out !== 5'd8) begin n_err++; $display("FAIL rst_mid_next_sum got=%0d exp=8", add_out); end
    step();
  endtask

  task automatic test_cnt_wrap();
    logic [3:0] exp_cnt;
    pulse_reset();
    out_rdy = 1'b1;
    for (int s = 1; s <= 19; s++) begin
      if (s <= 17) begin
        in_vld = 1'b1; add_in1 = 4'(s); add_in2 = 4'd0;
      end else begin
        in_vld = 1'b0;
      end
      step();
      exp_cnt = (s < 2) ? 4'd0 : 4'(s - 2);
      n_vec++; if (txn_cnt4 !== exp_cnt) begin n_err++; $display("FAIL wrap_cnt s=%0d got=%0d exp=%0d", s, txn_cnt4, exp_cnt); end
    end
    n_vec++; if (txn_cnt4 !== 4'd1) begin n_err++; $display("FAIL wrap_final got=%0d exp=1", txn_cnt4); end
    n_vec++; if (txn_cnt !== 16'd17) begin n_err++; $display("FAIL wrap_wide got=%0d exp=17", txn_cnt); end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    add_in1 = 4'd0;
    add_in2 = 4'd0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_single();
    test_sat();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
